bcd_10_2: RTL and testbench

- Pipelined BCD-to-binary converter; inverse of the team's binary-to-BCD digit-array converter.
- Takes a packed word of numberOfDigits BCD digits and produces its unsigned binary value.
- One pipeline stage per digit (Horner: acc = acc*10 + digit), with a valid flag travelling alongside each word and a global pipeline enable.
- Sits on the display/keypad input path, feeding binary arithmetic.

---
 rtl/bcd_10_2_pkg.sv | 31 +++
 rtl/bcd_10_2_stage.sv | 55 +++++
 rtl/bcd_10_2.sv | 108 ++++++++++
 tb/tb_bcd_10_2.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/bcd_10_2_pkg.sv
// Shared constants and helpers for the BCD-to-binary converter.
package bcd_pkg;

  // Largest legal value of one BCD digit; anything above marks the word bad.
  localparam int BCD_MAX_DIGIT = 9;
  // Radix of the digit stream.
  localparam int BCD_TEN = 10;
  // Narrowest digit bus that can carry a BCD digit.
  localparam int BCD_MIN_BUS_WIDTH = 4;
  // Widest word supported (10^9 still fits comfortably in 32 bits).
  localparam int BCD_MAX_DIGITS = 9;

  // Number of bits needed to hold every value below 10^numberOfDigits,
  // i.e. ceil(log2(10^numberOfDigits)).
  function automatic int binWidthOf(input int numberOfDigits);
    longint unsigned w_pow;
    int w_bits;
    w_pow = 64'd1;
    for (int i = 0; i < numberOfDigits; i++) begin
      w_pow = w_pow * 64'(BCD_TEN);
    end
    w_bits = 0;
    for (int b = 0; b < 64; b++) begin
      if ((64'd1 << w_bits) < w_pow) begin
        w_bits = w_bits + 1;
      end
    end
    return w_bits;
  endfunction

endpackage

// File: rtl/bcd_10_2_stage.sv
// One Horner step of the BCD-to-binary pipeline: acc_out = acc_in*10 + digit,
// with the word's valid flag and sticky bad-digit flag carried alongside.
module bcd_10_2_stage
  import bcd_pkg::*;
#(
  parameter int busWidth = 4,
  parameter int binWidth = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [binWidth-1:0] i_acc,
  input  logic [busWidth-1:0] i_digit,
  input  logic                i_valid,
  input  logic                i_err,
  output logic [binWidth-1:0] o_acc,
  output logic                o_valid,
  output logic                o_err
);

  logic [binWidth-1:0] w_acc_times_ten;
  logic [binWidth-1:0] w_digit_ext;
  logic [binWidth-1:0] w_acc_next;
  logic                w_digit_bad;

  logic [binWidth-1:0] r_acc;
  logic                r_valid;
  logic                r_err;

  // Multiply by ten as two shifts and an add, then fold in the new digit.
  always_comb begin
    w_acc_times_ten = (i_acc << 3) + (i_acc << 1);
    w_digit_ext     = binWidth'(i_digit);
    w_acc_next      = w_acc_times_ten + w_digit_ext;
    w_digit_bad     = (i_digit > busWidth'(BCD_MAX_DIGIT));
  end

  // Stage register; holds everything when the pipeline is stalled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_acc   <= '0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
    end else if (en) begin
      r_acc   <= w_acc_next;
      r_valid <= i_valid;
      r_err   <= i_err | w_digit_bad;
    end
  end

  assign o_acc   = r_acc;
  assign o_valid = r_valid;
  assign o_err   = r_err;

endmodule

// File: rtl/bcd_10_2.sv
// Pipelined BCD-to-binary converter. One Horner stage per digit, most
// significant digit first; lower digits wait in per-digit delay lines so
// each word's digits meet its own accumulator. Latency = numberOfDigits
// enabled cycles, one word per enabled cycle.
module bcd_10_2
  import bcd_pkg::*;
#(
  parameter  int numberOfDigits = 3,
  parameter  int busWidth       = 4,
  localparam int binWidth       = binWidthOf(numberOfDigits)
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    en,
  input  logic                                    validIn,
  input  logic [numberOfDigits-1:0][busWidth-1:0] digitIn,
  output logic                                    validOut,
  output logic [binWidth-1:0]                     binOut,
  output logic                                    errOut
);

  localparam int LAST = numberOfDigits - 1;

  // Elaboration-time guards on the parameter space.
  if (busWidth < BCD_MIN_BUS_WIDTH) begin : g_bad_bus_width
    $error("bcd_10_2: busWidth must be at least 4");
  end
  if ((numberOfDigits < 1) || (numberOfDigits > BCD_MAX_DIGITS)) begin : g_bad_digit_count
    $error("bcd_10_2: numberOfDigits must be in 1..9");
  end

  // Digit presented to each stage, already aligned with that stage's word.
  logic [busWidth-1:0] w_stage_digit [numberOfDigits];
  // Registered outputs of each stage.
  logic [binWidth-1:0] w_acc   [numberOfDigits];
  logic                w_valid [numberOfDigits];
  logic                w_err   [numberOfDigits];

  genvar gi;

  // The most significant digit enters stage 0 straight from the input.
  assign w_stage_digit[0] = digitIn[LAST];

  // Digit gi is consumed by stage (LAST-gi), so it rides a delay line of
  // exactly that many registers; all of them advance only with en.
  for (gi = 0; gi < numberOfDigits - 1; gi++) begin : g_skew
    localparam int DEPTH = LAST - gi;
    logic [DEPTH-1:0][busWidth-1:0] r_dly;

    // Shift the digit one stage deeper per enabled cycle.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_dly <= '0;
      end else if (en) begin
        r_dly[0] <= digitIn[gi];
        for (int k = 1; k < DEPTH; k++) begin
          r_dly[k] <= r_dly[k-1];
        end
      end
    end

    assign w_stage_digit[DEPTH] = r_dly[DEPTH-1];
  end

  // Chain of Horner stages; stage 0 starts from a zero accumulator.
  for (gi = 0; gi < numberOfDigits; gi++) begin : g_stage
    logic [binWidth-1:0] w_acc_in;
    logic                w_valid_in;
    logic                w_err_in;

    if (gi == 0) begin : g_head
      assign w_acc_in   = '0;
      assign w_valid_in = validIn;
      assign w_err_in   = 1'b0;
    end else begin : g_body
      assign w_acc_in   = w_acc[gi-1];
      assign w_valid_in = w_valid[gi-1];
      assign w_err_in   = w_err[gi-1];
    end

    bcd_10_2_stage #(
      .busWidth (busWidth),
      .binWidth (binWidth)
    ) u_stage (
      .clk     (clk),
      .rst     (rst),
      .en      (en),
      .i_acc   (w_acc_in),
      .i_digit (w_stage_digit[gi]),
      .i_valid (w_valid_in),
      .i_err   (w_err_in),
      .o_acc   (w_acc[gi]),
      .o_valid (w_valid[gi]),
      .o_err   (w_err[gi])
    );
  end

  // Output masking: bubbles show all-zero, bad words show err with a zero value.
  always_comb begin
    validOut = w_valid[LAST];
    errOut   = w_valid[LAST] & w_err[LAST];
    binOut   = '0;
    if (w_valid[LAST] && !w_err[LAST]) begin
      binOut = w_acc[LAST];
    end
  end

endmodule

// File: tb/tb_bcd_10_2.sv
// Randomised and directed bench for bcd_10_2 at 1, 3 and 4 digits. The
// reference model records every word accepted on an enabled edge and expects
// its decimal value to appear exactly N enabled edges later.
module tb_bcd_10_2;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        vin;
  logic [3:0]  d1;
  logic [11:0] d3;
  logic [15:0] d4;

  logic        vo1, eo1;
  logic [3:0]  bo1;
  logic        vo3, eo3;
  logic [9:0]  bo3;
  logic        vo4, eo4;
  logic [13:0] bo4;

  int n_cmp;
  int n_bad;

  // Model history, indexed by enabled-edge count since reset.
  int          ecount;
  bit          hv  [0:4095];
  logic [15:0] hw1 [0:4095];
  logic [15:0] hw3 [0:4095];
  logic [15:0] hw4 [0:4095];

  bcd_10_2 #(.numberOfDigits(1)) u_dut1 (
    .clk(clk), .rst(rst_n), .en(en), .validIn(vin), .digitIn(d1),
    .validOut(vo1), .binOut(bo1), .errOut(eo1));

  bcd_10_2 #(.numberOfDigits(3)) u_dut3 (
    .clk(clk), .rst(rst_n), .en(en), .validIn(vin), .digitIn(d3),
    .validOut(vo3), .binOut(bo3), .errOut(eo3));

  bcd_10_2 #(.numberOfDigits(4)) u_dut4 (
    .clk(clk), .rst(rst_n), .en(en), .validIn(vin), .digitIn(d4),
    .validOut(vo4), .binOut(bo4), .errOut(eo4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Decimal value of the low n nibbles; bit 32 flags any nibble above 9.
  function automatic logic [32:0] ref_conv(input logic [15:0] w, input int n);
    int v;
    int p;
    int d;
    bit e;
    v = 0;
    p = 1;
    e = 1'b0;
    for (int k = 0; k < n; k++) begin
      d = int'((w >> (4 * k)) & 16'hF);
      if (d > 9) e = 1'b1;
      v = v + d * p;
      p = p * 10;
    end
    if (e) return {1'b1, 32'd0};
    return {1'b0, 32'(v)};
  endfunction

  function automatic logic [15:0] rand_word();
    logic [15:0] w;
    for (int k = 0; k < 4; k++) begin
      if ($urandom_range(0, 7) == 0) w[4*k +: 4] = 4'($urandom_range(10, 15));
      else                           w[4*k +: 4] = 4'($urandom_range(0, 9));
    end
    return w;
  endfunction

  task automatic check_inst(input string ph, input int n, input logic vo,
                            input logic [31:0] bo, input logic eo);
    logic        ev;
    logic        ee;
    logic [31:0] eb;
    logic [15:0] w;
    logic [32:0] r;
    ev = 1'b0;
    ee = 1'b0;
    eb = 32'd0;
    if (ecount >= n && hv[ecount-n]) begin
      if (n == 1)      w = hw1[ecount-n];
      else if (n == 3) w = hw3[ecount-n];
      else             w = hw4[ecount-n];
      r  = ref_conv(w, n);
      ev = 1'b1;
      ee = r[32];
      eb = r[31:0];
    end
    chk($sformatf("%s.n%0d.validOut", ph, n), 32'(vo), 32'(ev));
    chk($sformatf("%s.n%0d.binOut", ph, n), bo, eb);
    chk($sformatf("%s.n%0d.errOut", ph, n), 32'(eo), 32'(ee));
  endtask

  task automatic check_all(input string ph);
    check_inst(ph, 1, vo1, 32'(bo1), eo1);
    check_inst(ph, 3, vo3, 32'(bo3), eo3);
    check_inst(ph, 4, vo4, 32'(bo4), eo4);
    if (vo3) $display("%s: n3 word out bin=%0d err=%0d", ph, bo3, eo3);
  endtask

  // One clock: record the accepted word on the edge, check on the falling edge.
  task automatic tick(input string ph);
    @(posedge clk);
    if (rst_n && en) begin
      hv[ecount]  = vin;
      hw1[ecount] = {12'd0, d1};
      hw3[ecount] = {4'd0, d3};
      hw4[ecount] = d4;
      ecount++;
    end
    @(negedge clk);
    check_all(ph);
  endtask

  task automatic issue3(input logic [11:0] w);
    vin = 1'b1;
    d3  = w;
    d1  = w[3:0];
    d4  = {4'd0, w};
  endtask

  initial begin
    logic [15:0] rw;
    n_cmp  = 0;
    n_bad  = 0;
    ecount = 0;
    rst_n  = 1'b0;
    en     = 1'b0;
    vin    = 1'b0;
    d1     = '0;
    d3     = '0;
    d4     = '0;

    repeat (2) @(negedge clk);
    check_all("reset");
    rst_n = 1'b1;
    en    = 1'b1;

    // Single word; the 1- and 4-digit copies see 7 and 9999.
    vin = 1'b1; d3 = 12'h123; d1 = 4'h7; d4 = 16'h9999;
    tick("single");
    vin = 1'b0;
    repeat (5) tick("single");

    // Back-to-back stream.
    issue3(12'h000); tick("stream");
    issue3(12'h999); tick("stream");
    issue3(12'h505); tick("stream");
    issue3(12'h001); tick("stream");
    vin = 1'b0;
    repeat (5) tick("stream");

    // Stall for five cycles right after issue.
    issue3(12'h487); tick("stall");
    vin = 1'b0; en = 1'b0;
    repeat (5) tick("stall");
    en = 1'b1;
    repeat (5) tick("stall");

    // Bad digits must not disturb the following good word.
    issue3(12'h1A3); tick("baddig");
    issue3(12'h0F0); tick("baddig");
    issue3(12'h042); tick("baddig");
    vin = 1'b0;
    repeat (5) tick("baddig");

    // Asynchronous reset with words in flight and a result on the outputs.
    issue3(12'h999); tick("midrst");
    issue3(12'h111); tick("midrst");
    issue3(12'h222); tick("midrst");
    vin = 1'b0;
    #2;
    rst_n  = 1'b0;
    ecount = 0;
    #1;
    chk("midrst.async.n1.validOut", 32'(vo1), 32'd0);
    chk("midrst.async.n3.validOut", 32'(vo3), 32'd0);
    chk("midrst.async.n3.binOut", 32'(bo3), 32'd0);
    chk("midrst.async.n4.validOut", 32'(vo4), 32'd0);
    chk("midrst.async.n4.binOut", 32'(bo4), 32'd0);
    @(posedge clk);
    @(negedge clk);
    check_all("midrst.held");
    rst_n = 1'b1;
    repeat (6) tick("postrst");

    // Random traffic with random stalls and bubbles.
    for (int i = 0; i < 500; i++) begin
      en  = ($urandom_range(0, 5) != 0);
      vin = ($urandom_range(0, 3) != 0);
      rw  = rand_word(); d1 = rw[3:0];
      rw  = rand_word(); d3 = rw[11:0];
      rw  = rand_word(); d4 = rw;
      tick("random");
    end
    en  = 1'b1;
    vin = 1'b0;
    repeat (6) tick("drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
